// File: rtl/wfetch_pkg.sv
// Shared types and constants for the weight fetch controller.
// Holds the FSM state encoding, fixed SRAM geometry (address/data width,
// beats per tile) and the bank-pair select values.
package wfetch_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ROWS   = 32;
    localparam int unsigned BEAT_W = $clog2(ROWS);

    // Pair select: PAIR_A = banks {4,5}, PAIR_B = banks {6,7}
    localparam logic PAIR_A = 1'b0;
    localparam logic PAIR_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        LOADED,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Return-path tracker: RD_LAT-deep shift of {valid, pair_sel} that mirrors
// the SRAM read latency so returned data can be tagged with its bank pair.
// Ports:
//   clk, rst            clock, synchronous active-high clear
//   in_valid, in_pair   read issued this cycle and its pair select
//   out_valid, out_pair tag for the data arriving this cycle
//   pend                a read is still in flight behind the output stage
module rd_return_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_pair,
    output logic out_valid,
    output logic out_pair,
    output logic pend
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] sel;

    // Shift toward the MSB; the concatenation drops the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            sel <= '0;
        end else begin
            vld <= DEPTH'({vld, in_valid});
            sel <= DEPTH'({sel, in_pair});
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_pair  = sel[DEPTH-1];
    // Any valid in stages other than the output stage
    assign pend      = |DEPTH'(vld << 1);

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: read master for weight SRAM banks 4..7.
// Issues ROWS-beat read bursts per tile, alternating bank pairs {4,5} and
// {6,7} per tile, and forwards returned data to the compute core.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base_addr,        job launch (accepted only in IDLE)
//   num_tiles                tiles per job (0 behaves as 1)
//   next_tile                controller pulse: fetch next tile (WAIT only)
//   bre_*, braddr_*          SRAM read enable/address per bank
//   rdata_*                  SRAM read data, RD_LAT cycles after bre
//   brvalid_*, brdata_*      data toward compute core (data 0 when invalid)
//   tile_loaded              pulse 2 cycles after the last beat of a tile
//   busy, job_done           job in progress / final tile loaded
//   perf_cycles              busy-cycle counter when WFETCH_PERF_EN is
//                            defined, otherwise constant 0
// RD_LAT supported range: 1..4.
module weight_fetch_ctrl
    import wfetch_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned TILE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              next_tile,
    output logic              bre_4,
    output logic              bre_5,
    output logic              bre_6,
    output logic              bre_7,
    output logic [ADDR_W-1:0] braddr_4,
    output logic [ADDR_W-1:0] braddr_5,
    output logic [ADDR_W-1:0] braddr_6,
    output logic [ADDR_W-1:0] braddr_7,
    input  logic [DATA_W-1:0] rdata_4,
    input  logic [DATA_W-1:0] rdata_5,
    input  logic [DATA_W-1:0] rdata_6,
    input  logic [DATA_W-1:0] rdata_7,
    output logic              brvalid_4,
    output logic              brvalid_5,
    output logic              brvalid_6,
    output logic              brvalid_7,
    output logic [DATA_W-1:0] brdata_4,
    output logic [DATA_W-1:0] brdata_5,
    output logic [DATA_W-1:0] brdata_6,
    output logic [DATA_W-1:0] brdata_7,
    output logic              tile_loaded,
    output logic              busy,
    output logic              job_done,
    output logic [31:0]       perf_cycles
);

    state_t            state, state_n;
    logic [BEAT_W-1:0] beat, beat_n;
    logic [TILE_W-1:0] tile, tile_n;
    logic [TILE_W-1:0] tile_last, tile_last_n;
    logic              pair, pair_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [3:0]        bre_q, bre_n;
    logic [ADDR_W-1:0] raddr_q [4];
    logic [ADDR_W-1:0] raddr_n [4];
    logic              tile_loaded_n, job_done_n, busy_n, fetch_n;
    logic              pipe_valid, pipe_pair, pipe_pend;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            tile        <= '0;
            tile_last   <= '0;
            pair        <= PAIR_A;
            addr        <= '0;
            bre_q       <= '0;
            raddr_q     <= '{default: '0};
            tile_loaded <= 1'b0;
            job_done    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            beat        <= beat_n;
            tile        <= tile_n;
            tile_last   <= tile_last_n;
            pair        <= pair_n;
            addr        <= addr_n;
            bre_q       <= bre_n;
            raddr_q     <= raddr_n;
            tile_loaded <= tile_loaded_n;
            job_done    <= job_done_n;
            busy        <= busy_n;
        end
    end

    // Next state; addr is the word issued this cycle and keeps counting
    // across tiles, so each tile starts at base + tile*ROWS for free.
    always_comb begin
        state_n       = state;
        beat_n        = beat;
        tile_n        = tile;
        tile_last_n   = tile_last;
        pair_n        = pair;
        addr_n        = addr;
        tile_loaded_n = 1'b0;
        job_done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = FETCH;
                    beat_n      = '0;
                    tile_n      = '0;
                    tile_last_n = (num_tiles == '0) ? '0 : num_tiles - TILE_W'(1);
                    pair_n      = PAIR_A;
                    addr_n      = base_addr;
                end
            end
            FETCH: begin
                addr_n = addr + ADDR_W'(1);
                if (beat == BEAT_W'(ROWS - 1)) begin
                    state_n = DRAIN;
                    beat_n  = '0;
                end else begin
                    beat_n = beat + BEAT_W'(1);
                end
            end
            // Leave when the final beat is at the pipe output with nothing behind it
            DRAIN: begin
                if (pipe_valid && !pipe_pend) begin
                    state_n = LOADED;
                end
            end
            LOADED: begin
                tile_loaded_n = 1'b1;
                if (tile == tile_last) begin
                    state_n    = DONE;
                    job_done_n = 1'b1;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (next_tile) begin
                    state_n = FETCH;
                    tile_n  = tile + TILE_W'(1);
                    pair_n  = ~pair;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        fetch_n = (state_n == FETCH);
        busy_n  = (state_n != IDLE);
        bre_n   = fetch_n ? ((pair_n == PAIR_B) ? 4'b1100 : 4'b0011) : 4'b0000;
        for (int k = 0; k < 4; k++) begin
            raddr_n[k] = bre_n[k] ? addr_n : '0;
        end
    end

    assign bre_4    = bre_q[0];
    assign bre_5    = bre_q[1];
    assign bre_6    = bre_q[2];
    assign bre_7    = bre_q[3];
    assign braddr_4 = raddr_q[0];
    assign braddr_5 = raddr_q[1];
    assign braddr_6 = raddr_q[2];
    assign braddr_7 = raddr_q[3];

    rd_return_pipe #(
        .DEPTH(RD_LAT)
    ) u_ret_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bre_q[0] | bre_q[2]),
        .in_pair  (bre_q[2]),
        .out_valid(pipe_valid),
        .out_pair (pipe_pair),
        .pend     (pipe_pend)
    );

    // Return data goes straight through; only the tag is pipelined
    assign brvalid_4 = pipe_valid && (pipe_pair == PAIR_A);
    assign brvalid_5 = pipe_valid && (pipe_pair == PAIR_A);
    assign brvalid_6 = pipe_valid && (pipe_pair == PAIR_B);
    assign brvalid_7 = pipe_valid && (pipe_pair == PAIR_B);
    assign brdata_4  = brvalid_4 ? rdata_4 : '0;
    assign brdata_5  = brvalid_5 ? rdata_5 : '0;
    assign brdata_6  = brvalid_6 ? rdata_6 : '0;
    assign brdata_7  = brvalid_7 ? rdata_7 : '0;

`ifdef WFETCH_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter, restarted by an accepted start, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state == IDLE && start) begin
            perf_q <= '0;
        end else if (busy && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl with RD_LAT=3. Stimulus pushes the expected
// per-beat {pair, address} into request and return queues; monitors pop and
// compare whenever bre or brvalid is seen. An SRAM model returns a
// bank/address-tagged pattern LAT cycles after each read.
module tb_weight_fetch_ctrl;
    import wfetch_pkg::*;

    localparam int unsigned LAT = 3;
    localparam int unsigned TW  = 8;

    typedef struct packed {
        logic              pair;
        logic [ADDR_W-1:0] addr;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              next_tile = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [TW-1:0]     num_tiles = '0;
    logic              bre_4, bre_5, bre_6, bre_7;
    logic [ADDR_W-1:0] braddr_4, braddr_5, braddr_6, braddr_7;
    logic [DATA_W-1:0] rdata_4, rdata_5, rdata_6, rdata_7;
    logic              brvalid_4, brvalid_5, brvalid_6, brvalid_7;
    logic [DATA_W-1:0] brdata_4, brdata_5, brdata_6, brdata_7;
    logic              tile_loaded, busy, job_done;
    logic [31:0]       perf_cycles;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_vld = -100;
    int req_cnt = 0;
    int perf_m = 0;

    beat_t req_q[$];
    beat_t ret_q[$];
    int    stamp_q[$];
    logic  jd_q[$];

    weight_fetch_ctrl #(.RD_LAT(LAT), .TILE_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_tiles(num_tiles), .next_tile(next_tile),
        .bre_4(bre_4), .bre_5(bre_5), .bre_6(bre_6), .bre_7(bre_7),
        .braddr_4(braddr_4), .braddr_5(braddr_5), .braddr_6(braddr_6), .braddr_7(braddr_7),
        .rdata_4(rdata_4), .rdata_5(rdata_5), .rdata_6(rdata_6), .rdata_7(rdata_7),
        .brvalid_4(brvalid_4), .brvalid_5(brvalid_5), .brvalid_6(brvalid_6), .brvalid_7(brvalid_7),
        .brdata_4(brdata_4), .brdata_5(brdata_5), .brdata_6(brdata_6), .brdata_7(brdata_7),
        .tile_loaded(tile_loaded), .busy(busy), .job_done(job_done), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] pat(input int bank, input logic [ADDR_W-1:0] a);
        return {8'(bank), 41'h0AB_CDEF_0123, a};
    endfunction

    // SRAM model: bank-tagged data LAT cycles after bre, garbage otherwise
    logic [3:0]        bre_v, vld_v;
    logic [ADDR_W-1:0] ra [4];
    logic [DATA_W-1:0] sr [4][LAT];
    assign bre_v = {bre_7, bre_6, bre_5, bre_4};
    assign vld_v = {brvalid_7, brvalid_6, brvalid_5, brvalid_4};
    assign ra[0] = braddr_4;
    assign ra[1] = braddr_5;
    assign ra[2] = braddr_6;
    assign ra[3] = braddr_7;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            for (int i = int'(LAT) - 1; i > 0; i--) sr[b][i] <= sr[b][i-1];
            sr[b][0] <= bre_v[b] ? pat(4 + b, ra[b]) : {32'hBAD0_0BAD, 32'(cyc)};
        end
    end
    assign rdata_4 = sr[0][LAT-1];
    assign rdata_5 = sr[1][LAT-1];
    assign rdata_6 = sr[2][LAT-1];
    assign rdata_7 = sr[3][LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [ADDR_W-1:0] base, input int tile, input logic last);
        for (int b = 0; b < int'(ROWS); b++) begin
            beat_t e;
            e.pair = tile[0];
            e.addr = ADDR_W'(32'(base) + 32'(tile) * ROWS + 32'(b));
            req_q.push_back(e);
            ret_q.push_back(e);
        end
        jd_q.push_back(last);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [TW-1:0] n);
        base_addr = b;
        num_tiles = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        perf_m = 0;
    endtask

    task automatic pulse_next();
        next_tile = 1'b1;
        tick();
        next_tile = 1'b0;
    endtask

    task automatic wait_tl(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tile_loaded && n < 400);
        chk(name, 64'(tile_loaded), 64'd1);
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        chk(name, 64'(busy), 64'd0);
        tick();
`ifdef WFETCH_PERF_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(perf_m));
`else
        chk("perf_off", 64'(perf_cycles), 64'd0);
`endif
        repeat (LAT + 40) tick();
        chk("req_left", 64'(req_q.size()), 64'd0);
        chk("ret_left", 64'(ret_q.size()), 64'd0);
        chk("jd_left", 64'(jd_q.size()), 64'd0);
    endtask

    // Monitor: request side, return side, tile_loaded/job_done timing
    always @(negedge clk) begin : mon
        beat_t e;
        int    st;
        if (!rst) begin
            if (busy) perf_m++;
            if (|bre_v) begin
                req_cnt++;
                if (req_q.size() == 0) begin
                    chk("req_extra", 64'(bre_v), 64'd0);
                end else begin
                    e = req_q.pop_front();
                    chk("req_banks", 64'(bre_v), e.pair ? 64'hC : 64'h3);
                    chk("req_addr_even", 64'(e.pair ? ra[2] : ra[0]), 64'(e.addr));
                    chk("req_addr_odd", 64'(e.pair ? ra[3] : ra[1]), 64'(e.addr));
                    stamp_q.push_back(cyc);
                end
            end
            if (|vld_v) begin
                if (ret_q.size() == 0) begin
                    chk("ret_extra", 64'(vld_v), 64'd0);
                end else begin
                    e  = ret_q.pop_front();
                    st = (stamp_q.size() != 0) ? stamp_q.pop_front() : -1000;
                    chk("ret_banks", 64'(vld_v), e.pair ? 64'hC : 64'h3);
                    chk("ret_latency", 64'(cyc - st), 64'(LAT));
                    chk("ret_data_even", e.pair ? brdata_6 : brdata_4, pat(e.pair ? 6 : 4, e.addr));
                    chk("ret_data_odd", e.pair ? brdata_7 : brdata_5, pat(e.pair ? 7 : 5, e.addr));
                    chk("ret_data_other", e.pair ? (brdata_4 | brdata_5) : (brdata_6 | brdata_7), 64'd0);
                end
                last_vld = cyc;
            end else begin
                chk("idle_data_zero", brdata_4 | brdata_5 | brdata_6 | brdata_7, 64'd0);
            end
            if (tile_loaded) begin
                chk("tile_loaded_lag", 64'(cyc - last_vld), 64'd2);
                chk("tile_beats_left", 64'(ret_q.size()), 64'd0);
                if (jd_q.size() == 0) chk("tile_loaded_extra", 64'd1, 64'd0);
                else chk("job_done", 64'(job_done), 64'(jd_q.pop_front()));
            end else if (job_done) begin
                chk("job_done_stray", 64'd1, 64'd0);
            end
        end
    end

    initial begin : stim
        int n;
        int rc0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        // Reset state
        chk("rst_bre", 64'(bre_v), 64'd0);
        chk("rst_brvalid", 64'(vld_v), 64'd0);
        chk("rst_braddr", 64'(braddr_4 | braddr_5 | braddr_6 | braddr_7), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tile_loaded", 64'(tile_loaded), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        chk("rst_perf", 64'(perf_cycles), 64'd0);

        // Single tile from 0x0100
        push_tile(15'h0100, 0, 1'b1);
        do_start(15'h0100, 8'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_tl("t1_tile_loaded_seen");
        wait_idle("t1_busy_drop");

        // Three tiles, pairs A/B/A
        push_tile(15'h0100, 0, 1'b0);
        do_start(15'h0100, 8'd3);
        wait_tl("t2_tile0_seen");
        push_tile(15'h0100, 1, 1'b0);
        pulse_next();
        wait_tl("t2_tile1_seen");
        push_tile(15'h0100, 2, 1'b1);
        pulse_next();
        wait_tl("t2_tile2_seen");
        wait_idle("t2_busy_drop");

        // Address wrap at top of space
        push_tile(15'h7FF0, 0, 1'b1);
        do_start(15'h7FF0, 8'd1);
        wait_tl("t3_tile_loaded_seen");
        wait_idle("t3_busy_drop");

        // Reset during beat 10 of a burst
        push_tile(15'h0200, 0, 1'b1);
        rc0 = req_cnt;
        do_start(15'h0200, 8'd1);
        n = 0;
        while (req_cnt < rc0 + 10 && n < 100) begin
            tick();
            n++;
        end
        chk("t4_reached_beat10", 64'(req_cnt - rc0), 64'd10);
        rst = 1'b1;
        tick();
        chk("t4_bre_cleared", 64'(bre_v), 64'd0);
        chk("t4_brvalid_cleared", 64'(vld_v), 64'd0);
        chk("t4_busy_cleared", 64'(busy), 64'd0);
        req_q.delete();
        ret_q.delete();
        stamp_q.delete();
        jd_q.delete();
        perf_m = 0;
        tick();
        rst = 1'b0;
        tick();
        chk("t4_brvalid_after", 64'(vld_v), 64'd0);
        push_tile(15'h0000, 0, 1'b1);
        do_start(15'h0000, 8'd1);
        wait_tl("t4_clean_tile_seen");
        wait_idle("t4_busy_drop");

        // num_tiles=0, start while busy, next_tile during FETCH
        push_tile(15'h2000, 0, 1'b1);
        do_start(15'h2000, 8'd0);
        repeat (5) tick();
        base_addr = 15'h6000;
        num_tiles = 8'd2;
        start = 1'b1;
        next_tile = 1'b1;
        tick();
        start = 1'b0;
        next_tile = 1'b0;
        wait_tl("t5_tile_loaded_seen");
        wait_idle("t5_busy_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
